// File: rtl/serial_addsub.sv
// serial_addsub: digit-serial add/subtract unit.
// Operands are accepted in one cycle. They are then summed DIGIT bits per
// enabled cycle, least-significant slice first. The result is registered
// together with its carry/borrow, overflow, zero and negative flags. Signed
// modes clamp to the most-positive or most-negative value on overflow.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             neg
);

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CNT_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int SUM_W = DIGIT + 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                    state;
    logic [WIDTH-1:0]          a_sh;      // remaining slices of a, LSB slice at bottom
    logic [WIDTH-1:0]          b_sh;      // remaining slices of b' (b inverted for subtract)
    logic [WIDTH-1:0]          sum_sr;    // sum slices collected so far, filled from the top
    logic                      cy;        // running carry between slices
    logic                      a_msb;     // sign of a, kept for overflow/saturation
    logic                      b_msb;     // sign of b', kept for overflow
    logic                      sub_mode;  // borrow is the inverted carry-out
    logic                      sat_mode;  // clamp on signed overflow
    logic [CNT_W-1:0]          cnt;

    logic [SUM_W-1:0]          slice_sum;
    logic signed [WIDTH-1:0]   raw_sum;
    logic                      raw_ovf;
    logic signed [WIDTH-1:0]   final_res;

    // Shift the newest sum slice into the top of the collector.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] sr,
                                                  input logic [DIGIT-1:0] s);
        return (sr >> DIGIT) | (WIDTH'(s) << (WIDTH - DIGIT));
    endfunction

    // Clamp toward the sign of a when the signed result has overflowed.
    function automatic logic signed [WIDTH-1:0] saturate(input logic signed [WIDTH-1:0] raw,
                                                         input logic ovf,
                                                         input logic a_neg);
        logic signed [WIDTH-1:0] max_pos;
        logic signed [WIDTH-1:0] min_neg;
        max_pos = {1'b0, {(WIDTH-1){1'b1}}};
        min_neg = {1'b1, {(WIDTH-1){1'b0}}};
        if (!ovf)
            return raw;
        return a_neg ? min_neg : max_pos;
    endfunction

    assign in_ready  = (state == IDLE) && ena;
    assign out_valid = (state == DONE);

    // Per-slice adder and the complete result. The complete result is only
    // meaningful while the last slice is being added.
    always_comb begin
        slice_sum = {1'b0, a_sh[DIGIT-1:0]} + {1'b0, b_sh[DIGIT-1:0]} + SUM_W'(cy);
        raw_sum   = shift_in(sum_sr, slice_sum[DIGIT-1:0]);
        raw_ovf   = (a_msb == b_msb) && (raw_sum[WIDTH-1] != a_msb);
        final_res = saturate(raw_sum, raw_ovf && sat_mode, a_msb);
    end

    // Control FSM and datapath state. Everything is frozen while ena is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            sum_sr   <= '0;
            cy       <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            sub_mode <= 1'b0;
            sat_mode <= 1'b0;
            result   <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
            neg      <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= op_a;
                        b_sh     <= mode[0] ? op_b : ~op_b;
                        a_msb    <= op_a[WIDTH-1];
                        b_msb    <= mode[0] ? op_b[WIDTH-1] : ~op_b[WIDTH-1];
                        sub_mode <= ~mode[0];
                        sat_mode <= mode[1];
                        cy       <= ~mode[0];
                        cnt      <= '0;
                        sum_sr   <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    a_sh   <= a_sh >> DIGIT;
                    b_sh   <= b_sh >> DIGIT;
                    sum_sr <= raw_sum;
                    cy     <= slice_sum[DIGIT];
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(STEPS - 1)) begin
                        cnt      <= '0;
                        result   <= final_res;
                        carry    <= slice_sum[DIGIT] ^ sub_mode;
                        overflow <= raw_ovf;
                        zero     <= (final_res == '0);
                        neg      <= final_res[WIDTH-1];
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
